// File: rtl/wrlvl_seq.sv
// -----------------------------------------------------------------------------
// wrlvl_seq : DFI write-levelling sequencer
//
// On a training request this block raises dfi_wrlvl_en plus the chip select of
// the selected rank, waits TWLMRD cycles, then issues one-cycle strobes spaced
// by STROBE_GAP idle cycles.  The lanes' responses are AND-ed and sampled only
// during the gap cycles.  The run ends successfully when every lane has
// responded, or with a timeout once MAX_STROBES strobes went unanswered.
//
// Ports
//   SCLK              in   system clock, rising edge
//   reset             in   asynchronous active-high reset
//   start             in   level request, accepted only in IDLE
//   rank_sel          in   0: rank 0, 1: rank 1 (latched at accept)
//   dfi_wrlvl_resp    in   per-lane write-levelling response
//   dfi_wrlvl_en      out  write-levelling enable to the lanes
//   dfi_wrlvl_strobe  out  one-cycle strobe pulse
//   dfi_wrlvl_cs_0_n  out  active-low rank-0 select while levelling
//   dfi_wrlvl_cs_1_n  out  active-low rank-1 select while levelling
//   busy              out  run in progress (MRD_WAIT/STROBE/GAP/EXIT)
//   done              out  success, held until start drops
//   timeout_err       out  timeout, held until start drops
//   strobe_count      out  strobes issued this run, held after finish
// -----------------------------------------------------------------------------
module wrlvl_seq #(
  parameter int IOG_DQS_LANES = 9,
  parameter int TWLMRD        = 40,
  parameter int STROBE_GAP    = 16,
  parameter int EXIT_WAIT     = 8,
  parameter int MAX_STROBES   = 200
) (
  input  logic                     SCLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     rank_sel,
  input  logic [IOG_DQS_LANES-1:0] dfi_wrlvl_resp,
  output logic                     dfi_wrlvl_en,
  output logic                     dfi_wrlvl_strobe,
  output logic                     dfi_wrlvl_cs_0_n,
  output logic                     dfi_wrlvl_cs_1_n,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [7:0]               strobe_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MRD_WAIT,
    S_STROBE,
    S_GAP,
    S_EXIT,
    S_DONE,
    S_ERR
  } state_t;

  // Down-counters are loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [7:0] MRD_LOAD  = 8'(TWLMRD - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(STROBE_GAP - 1);
  localparam logic [7:0] EXIT_LOAD = 8'(EXIT_WAIT - 1);
  localparam logic [7:0] MAX_CNT   = 8'(MAX_STROBES);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] strobe_count_next;
  logic       resp_seen_reg, resp_seen_next;
  logic       rank_reg, rank_next;
  logic       all_resp;
  logic       gap_seen;

  logic en_next, strobe_next, busy_next, done_next, err_next;
  logic cs_0_n_next, cs_1_n_next;

  assign all_resp = &dfi_wrlvl_resp;
  // The current gap cycle's response counts toward the exit decision.
  assign gap_seen = resp_seen_reg | all_resp;

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    strobe_count_next = strobe_count;
    resp_seen_next    = resp_seen_reg;
    rank_next         = rank_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next        = S_MRD_WAIT;
          cnt_next          = MRD_LOAD;
          rank_next         = rank_sel;
          strobe_count_next = 8'd0;
          resp_seen_next    = 1'b0;
        end
      end
      S_MRD_WAIT: begin
        if (cnt_reg == 8'd0) state_next = S_STROBE;
        else                 cnt_next   = cnt_reg - 8'd1;
      end
      S_STROBE: begin
        state_next = S_GAP;
        cnt_next   = GAP_LOAD;
      end
      S_GAP: begin
        resp_seen_next = gap_seen;
        if (cnt_reg == 8'd0) begin
          if (gap_seen) begin
            state_next = S_EXIT;
            cnt_next   = EXIT_LOAD;
          end else if (strobe_count == MAX_CNT) begin
            state_next = S_ERR;
          end else begin
            state_next = S_STROBE;
          end
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      S_EXIT: begin
        if (cnt_reg == 8'd0) state_next = S_DONE;
        else                 cnt_next   = cnt_reg - 8'd1;
      end
      S_DONE, S_ERR: begin
        // A held start must not retrigger; wait for it to drop first.
        if (!start) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // STROBE always lasts one cycle, so entering it is one strobe.
    if (state_next == S_STROBE && strobe_count_next != 8'hFF)
      strobe_count_next = strobe_count_next + 8'd1;

    // Outputs decoded from the next state and registered alongside it.
    en_next     = (state_next == S_MRD_WAIT) || (state_next == S_STROBE) ||
                  (state_next == S_GAP);
    strobe_next = (state_next == S_STROBE);
    busy_next   = en_next || (state_next == S_EXIT);
    done_next   = (state_next == S_DONE);
    err_next    = (state_next == S_ERR);
    cs_0_n_next = ~(en_next & ~rank_next);
    cs_1_n_next = ~(en_next & rank_next);
  end

  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= 8'd0;
      resp_seen_reg    <= 1'b0;
      rank_reg         <= 1'b0;
      strobe_count     <= 8'd0;
      dfi_wrlvl_en     <= 1'b0;
      dfi_wrlvl_strobe <= 1'b0;
      dfi_wrlvl_cs_0_n <= 1'b1;
      dfi_wrlvl_cs_1_n <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      resp_seen_reg    <= resp_seen_next;
      rank_reg         <= rank_next;
      strobe_count     <= strobe_count_next;
      dfi_wrlvl_en     <= en_next;
      dfi_wrlvl_strobe <= strobe_next;
      dfi_wrlvl_cs_0_n <= cs_0_n_next;
      dfi_wrlvl_cs_1_n <= cs_1_n_next;
      busy             <= busy_next;
      done             <= done_next;
      timeout_err      <= err_next;
    end
  end

endmodule

// File: tb/tb_wrlvl_seq.sv
// -----------------------------------------------------------------------------
// tb_wrlvl_seq : directed bench for wrlvl_seq with default parameters.
// Cycle n of a run is the clock period whose outputs reflect n edges after the
// request; inputs set in cycle n are sampled by the edge that ends it.
// -----------------------------------------------------------------------------
module tb_wrlvl_seq;

  logic       SCLK = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rank_sel = 1'b0;
  logic [8:0] dfi_wrlvl_resp = 9'h000;
  logic       dfi_wrlvl_en, dfi_wrlvl_strobe, dfi_wrlvl_cs_0_n, dfi_wrlvl_cs_1_n;
  logic       busy, done, timeout_err;
  logic [7:0] strobe_count;

  wrlvl_seq dut (
    .SCLK             (SCLK),
    .reset            (reset),
    .start            (start),
    .rank_sel         (rank_sel),
    .dfi_wrlvl_resp   (dfi_wrlvl_resp),
    .dfi_wrlvl_en     (dfi_wrlvl_en),
    .dfi_wrlvl_strobe (dfi_wrlvl_strobe),
    .dfi_wrlvl_cs_0_n (dfi_wrlvl_cs_0_n),
    .dfi_wrlvl_cs_1_n (dfi_wrlvl_cs_1_n),
    .busy             (busy),
    .done             (done),
    .timeout_err      (timeout_err),
    .strobe_count     (strobe_count)
  );

  always #5 SCLK = ~SCLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic       en;
    logic       strobe;
    logic       busy;
    logic       done;
    logic       cs0n;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SCLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Current cycle must be IDLE; it becomes cycle 0 of the new run.
  task automatic new_run(input logic r);
    start    = 1'b1;
    rank_sel = r;
    cyc      = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en"},     16'(dfi_wrlvl_en),     16'd0);
    check({tag, "_strobe"}, 16'(dfi_wrlvl_strobe), 16'd0);
    check({tag, "_cs0n"},   16'(dfi_wrlvl_cs_0_n), 16'd1);
    check({tag, "_cs1n"},   16'(dfi_wrlvl_cs_1_n), 16'd1);
    check({tag, "_busy"},   16'(busy),             16'd0);
    check({tag, "_done"},   16'(done),             16'd0);
    check({tag, "_err"},    16'(timeout_err),      16'd0);
    check({tag, "_cnt"},    16'(strobe_count),     16'd0);
  endtask

  int bad_cs;

  initial begin
    // Basic run: start at cycle 0, full response from cycle 60.
    //            cyc  en strb busy done cs0n cnt
    tbl[0]  = '{  0,  0, 0,   0,   0,   1,   0};
    tbl[1]  = '{  1,  1, 0,   1,   0,   0,   0};
    tbl[2]  = '{ 40,  1, 0,   1,   0,   0,   0};
    tbl[3]  = '{ 41,  1, 1,   1,   0,   0,   1};
    tbl[4]  = '{ 42,  1, 0,   1,   0,   0,   1};
    tbl[5]  = '{ 57,  1, 0,   1,   0,   0,   1};
    tbl[6]  = '{ 58,  1, 1,   1,   0,   0,   2};
    tbl[7]  = '{ 74,  1, 0,   1,   0,   0,   2};
    tbl[8]  = '{ 75,  0, 0,   1,   0,   1,   2};
    tbl[9]  = '{ 82,  0, 0,   1,   0,   1,   2};
    tbl[10] = '{ 83,  0, 0,   0,   1,   1,   2};
    tbl[11] = '{ 90,  0, 0,   0,   1,   1,   2};

    // Reset values while reset is held.
    #12;
    check_reset_values("rst_hold");
    @(posedge SCLK);
    #1;
    reset = 1'b0;
    step();

    new_run(1'b0);
    for (int i = 0; i < 12; i++) begin
      while (cyc < tbl[i].cyc) begin
        step();
        if (cyc == 60) dfi_wrlvl_resp = 9'h1FF;
      end
      check($sformatf("basic_en_%0d", i),     16'(dfi_wrlvl_en),     16'(tbl[i].en));
      check($sformatf("basic_strobe_%0d", i), 16'(dfi_wrlvl_strobe), 16'(tbl[i].strobe));
      check($sformatf("basic_busy_%0d", i),   16'(busy),             16'(tbl[i].busy));
      check($sformatf("basic_done_%0d", i),   16'(done),             16'(tbl[i].done));
      check($sformatf("basic_cs0n_%0d", i),   16'(dfi_wrlvl_cs_0_n), 16'(tbl[i].cs0n));
      check($sformatf("basic_cs1n_%0d", i),   16'(dfi_wrlvl_cs_1_n), 16'd1);
      check($sformatf("basic_cnt_%0d", i),    16'(strobe_count),     16'(tbl[i].cnt));
    end

    // Handshake: start held high after DONE must not retrigger.
    run_to(100);
    check("hold_done", 16'(done), 16'd1);
    check("hold_en",   16'(dfi_wrlvl_en), 16'd0);
    check("hold_busy", 16'(busy), 16'd0);
    start = 1'b0;
    step();
    check("drop_done", 16'(done), 16'd0);
    check("drop_cnt",  16'(strobe_count), 16'd2);
    new_run(1'b0);
    step();
    check("rerun_en",   16'(dfi_wrlvl_en), 16'd1);
    check("rerun_busy", 16'(busy), 16'd1);
    check("rerun_done", 16'(done), 16'd0);
    check("rerun_cnt",  16'(strobe_count), 16'd0);

    // Reset asserted during GAP, between clock edges.
    run_to(45);
    check("pre_rst_cnt", 16'(strobe_count), 16'd1);
    check("pre_rst_en",  16'(dfi_wrlvl_en), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("rst_mid");
    dfi_wrlvl_resp = 9'h000;
    @(posedge SCLK);
    #1;
    reset = 1'b0;
    new_run(1'b0);
    step();
    check("fresh_en",  16'(dfi_wrlvl_en), 16'd1);
    check("fresh_cnt", 16'(strobe_count), 16'd0);

    // One-cycle full response inside GAP: exit after the current GAP.
    run_to(41);
    check("fresh_strobe", 16'(dfi_wrlvl_strobe), 16'd1);
    check("fresh_cnt1",   16'(strobe_count), 16'd1);
    run_to(45);
    dfi_wrlvl_resp = 9'h1FF;
    step();
    dfi_wrlvl_resp = 9'h000;
    run_to(57);
    check("gap_pulse_en57", 16'(dfi_wrlvl_en), 16'd1);
    step();
    check("gap_pulse_en58",     16'(dfi_wrlvl_en), 16'd0);
    check("gap_pulse_strobe58", 16'(dfi_wrlvl_strobe), 16'd0);
    check("gap_pulse_busy58",   16'(busy), 16'd1);
    run_to(66);
    check("gap_pulse_done", 16'(done), 16'd1);
    check("gap_pulse_cnt",  16'(strobe_count), 16'd1);
    start = 1'b0;
    step();

    // Full response only in the STROBE cycle is ignored; then partial
    // response held until timeout.
    new_run(1'b0);
    run_to(41);
    check("strb_pulse_strobe", 16'(dfi_wrlvl_strobe), 16'd1);
    dfi_wrlvl_resp = 9'h1FF;
    step();
    dfi_wrlvl_resp = 9'h0FF;
    run_to(58);
    check("strb_pulse_next_strobe", 16'(dfi_wrlvl_strobe), 16'd1);
    check("strb_pulse_cnt",         16'(strobe_count), 16'd2);
    run_to(3440);
    check("to_pre_en",  16'(dfi_wrlvl_en), 16'd1);
    check("to_pre_err", 16'(timeout_err), 16'd0);
    check("to_pre_cnt", 16'(strobe_count), 16'd200);
    step();
    check("to_en",     16'(dfi_wrlvl_en), 16'd0);
    check("to_err",    16'(timeout_err), 16'd1);
    check("to_done",   16'(done), 16'd0);
    check("to_busy",   16'(busy), 16'd0);
    check("to_strobe", 16'(dfi_wrlvl_strobe), 16'd0);
    check("to_cnt",    16'(strobe_count), 16'd200);
    step();
    check("to_err_hold", 16'(timeout_err), 16'd1);
    check("to_cnt_hold", 16'(strobe_count), 16'd200);
    start = 1'b0;
    step();
    check("to_err_clr", 16'(timeout_err), 16'd0);

    // Rank 1 latched at accept; rank_sel toggled mid-run has no effect.
    // Response present during MRD_WAIT is only counted once GAP samples it.
    dfi_wrlvl_resp = 9'h000;
    new_run(1'b1);
    bad_cs = 0;
    while (cyc < 57) begin
      step();
      if (cyc == 5)  dfi_wrlvl_resp = 9'h1FF;
      if (cyc == 10) rank_sel = 1'b0;
      if (dfi_wrlvl_cs_1_n !== 1'b0 || dfi_wrlvl_cs_0_n !== 1'b1) bad_cs++;
    end
    check("rank1_cs_window", 16'(bad_cs), 16'd0);
    check("rank1_cnt57",     16'(strobe_count), 16'd1);
    step();
    check("rank1_en58",   16'(dfi_wrlvl_en), 16'd0);
    check("rank1_cs1n58", 16'(dfi_wrlvl_cs_1_n), 16'd1);
    check("rank1_cs0n58", 16'(dfi_wrlvl_cs_0_n), 16'd1);
    run_to(66);
    check("rank1_done", 16'(done), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
